text_char_fetch: RTL and testbench
==================================

Name: text_char_fetch

Overview:
- Parametrised successor of the text-area character lookup. Maps a (column, row) character position to a linear text-RAM address and returns the stored ASCII code and colour byte through a registered, valid-tagged pipeline.
- Adds four features:
  - a write port with a valid/ready handshake for host updates;
  - a hardware clear-screen sequencer;
  - out-of-range blanking;
  - a frame-counted blinking cursor.
- Sits between the VGA timing/position counters and the glyph ROM lookup.

Parameters:
- COLS, 80, characters per row
- ROWS, 60, character rows
- COL_W, 7, width of column coordinates
- ROW_W, 7, width of row coordinates
- ADDR_W, 13, text RAM address width (must satisfy 2^ADDR_W >= COLS*ROWS)
- CHAR_W, 8, ASCII field width
- COLOR_W, 8, colour field width (must be even)
- BLANK_CHAR, 8'h20, character written by clear and returned for out-of-range reads
- CLEAR_COLOR, 8'h0F, colour written by clear
- BLINK_FRAMES, 30, number of frame_start pulses per cursor phase

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_valid  in  1  read request this cycle
- rd_col  in  COL_W  character column
- rd_row  in  ROW_W  character row
- out_valid  out  1  ascii/text_color valid
- ascii  out  CHAR_W  character code
- text_color  out  COLOR_W  colour byte, after cursor modification
- wr_valid  in  1  host write request
- wr_ready  out  1  write port can accept
- wr_col  in  COL_W  write column
- wr_row  in  ROW_W  write row
- wr_data  in  COLOR_W+CHAR_W  {color, ascii}
- clr_req  in  1  pulse: start clear-screen
- clr_busy  out  1  clear sequence in progress
- frame_start  in  1  one-cycle pulse per video frame
- cursor_en  in  1  cursor enable
- cursor_col  in  COL_W  cursor column
- cursor_row  in  ROW_W  cursor row

Behaviour:
- Address arithmetic: addr = row*COLS + col, computed at ADDR_W bits with no truncation inside the valid range.
- Text RAM:
  - inferred simple dual-port RAM, COLS*ROWS words of COLOR_W+CHAR_W bits;
  - synchronous read, read-first;
  - contents are not reset.
- Read pipeline, three stages, fixed latency 3:
  - S1 registers addr, the range flag (col>=COLS or row>=ROWS) and the cursor match;
  - S2 performs the RAM read;
  - S3 is the output register.
- out_valid is asserted exactly 3 cycles after rd_valid. The pipeline cannot stall and accepts back-to-back requests every cycle.
- Out-of-range read: ascii=BLANK_CHAR, text_color=0. Memory contents are unaffected.
- Write port:
  - wr_ready = ~clr_busy, and is 0 while in reset;
  - a write is accepted when wr_valid && wr_ready and commits at that clock edge;
  - an out-of-range write is accepted (handshake completes) but discarded.
- Same-address write and read in the same cycle: the read returns the old data.
- Clear FSM, states IDLE -> CLEAR -> IDLE:
  - clr_req in IDLE: enter CLEAR with clr_ptr=0;
  - in CLEAR: write {CLEAR_COLOR, BLANK_CHAR} to clr_ptr each cycle and increment;
  - after writing COLS*ROWS-1, return to IDLE; total COLS*ROWS cycles;
  - clr_busy=1 exactly while in CLEAR;
  - clr_req during CLEAR is ignored, not queued.
- Reads remain serviced during CLEAR and return the current RAM contents.
- Blink:
  - blink_cnt counts frame_start pulses from 0 to BLINK_FRAMES-1;
  - on the pulse at BLINK_FRAMES-1 it wraps to 0 and toggles blink_phase.
- Cursor: when cursor_en && blink_phase && (rd_col,rd_row)==(cursor_col,cursor_row) (sampled in S1), and the request is in range, text_color swaps its halves: {c[COLOR_W/2-1:0], c[COLOR_W-1:COLOR_W/2]}.
- Reset, asynchronous, including mid-operation:
  - out_valid=0, ascii=0, text_color=0;
  - pipeline valid bits cleared;
  - FSM to IDLE, clr_busy=0, clr_ptr=0;
  - blink_cnt=0, blink_phase=0.
- Reset mid-clear leaves RAM partially cleared; no recovery is attempted.

Test Plan:
- Write {8'h1E,8'h41} to col 5, row 2, then read (5,2) -> 3 cycles later out_valid=1, ascii=8'h41, text_color=8'h1E. Check RAM address 165.
- Pulse clr_req -> clr_busy high for exactly 4800 cycles and wr_ready low throughout. Then read (0,0), (79,59) and (40,30) -> ascii=8'h20, text_color=8'h0F.
- Read (80,0) and (0,60) -> ascii=8'h20, text_color=8'h00. Write to (80,0) -> accepted; (0,1) is unchanged.
- Stream reads of (0,0)..(79,0) on consecutive cycles -> 80 consecutive out_valid cycles, in order, with no gaps.
- Cursor at (3,3) with cursor_en=1 and colour 8'h1E stored there:
  - before 30 frame_start pulses -> text_color=8'h1E;
  - after 30 pulses -> 8'hE1;
  - after 60 pulses -> 8'h1E;
  - a neighbouring cell stays unmodified.
- Assert rst_n=0 for one cycle in the middle of a clear and during active reads -> outputs and out_valid go to 0 immediately, clr_busy=0, and wr_ready=1 after release.

Source files
------------

// File: rtl/text_char_fetch.sv
// Character-cell text buffer: maps (col,row) to a text-RAM word and returns
// {colour, ascii} through a fixed 3-stage pipeline, with host writes, clear-screen and cursor blink.
module text_char_fetch #(
   parameter int unsigned COLS         = 80,
   parameter int unsigned ROWS         = 60,
   parameter int unsigned COL_W        = 7,
   parameter int unsigned ROW_W        = 7,
   parameter int unsigned ADDR_W       = 13,
   parameter int unsigned CHAR_W       = 8,
   parameter int unsigned COLOR_W      = 8,
   parameter logic [CHAR_W-1:0]  BLANK_CHAR  = 8'h20,
   parameter logic [COLOR_W-1:0] CLEAR_COLOR = 8'h0F,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       rd_valid,
   input  logic [COL_W-1:0]           rd_col,
   input  logic [ROW_W-1:0]           rd_row,
   output logic                       out_valid,
   output logic [CHAR_W-1:0]          ascii,
   output logic [COLOR_W-1:0]         text_color,
   input  logic                       wr_valid,
   output logic                       wr_ready,
   input  logic [COL_W-1:0]           wr_col,
   input  logic [ROW_W-1:0]           wr_row,
   input  logic [COLOR_W+CHAR_W-1:0]  wr_data,
   input  logic                       clr_req,
   output logic                       clr_busy,
   input  logic                       frame_start,
   input  logic                       cursor_en,
   input  logic [COL_W-1:0]           cursor_col,
   input  logic [ROW_W-1:0]           cursor_row
);

   localparam int unsigned WORDS   = COLS * ROWS;
   localparam int unsigned DATA_W  = COLOR_W + CHAR_W;
   localparam int unsigned HALF    = COLOR_W / 2;
   localparam int unsigned CW1     = COL_W + 1;
   localparam int unsigned RW1     = ROW_W + 1;
   localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   typedef enum logic {IDLE, CLEAR} state_t;

   // One extra bit on each side keeps the comparison exact even when COLS == 2^COL_W.
   function automatic logic in_range(input logic [COL_W-1:0] c, input logic [ROW_W-1:0] r);
      return ({1'b0, c} < CW1'(COLS)) && ({1'b0, r} < RW1'(ROWS));
   endfunction

   function automatic logic [ADDR_W-1:0] lin_addr(input logic [COL_W-1:0] c,
                                                  input logic [ROW_W-1:0] r);
      return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
   endfunction

   state_t               state;
   logic [ADDR_W-1:0]    clr_ptr;

   logic [BLINK_W-1:0]   blink_cnt;
   logic                 blink_phase;

   logic                 ram_we;
   logic [ADDR_W-1:0]    ram_waddr;
   logic [DATA_W-1:0]    ram_wdata;
   logic [DATA_W-1:0]    mem [0:WORDS-1];
   logic [DATA_W-1:0]    ram_q;

   logic                 rd_in;
   logic                 wr_in;
   logic                 cur_hit;

   logic                 s1_valid;
   logic [ADDR_W-1:0]    s1_addr;
   logic                 s1_oor;
   logic                 s1_cur;
   logic                 s2_valid;
   logic                 s2_oor;
   logic                 s2_cur;

   logic [COLOR_W-1:0]   q_color;
   logic [CHAR_W-1:0]    q_char;

   assign rd_in   = in_range(rd_col, rd_row);
   assign wr_in   = in_range(wr_col, wr_row);
   assign cur_hit = cursor_en && blink_phase && rd_in &&
                    (rd_col == cursor_col) && (rd_row == cursor_row);
   assign q_color = ram_q[DATA_W-1:CHAR_W];
   assign q_char  = ram_q[CHAR_W-1:0];

   // Clear sequencer; wr_ready is registered and tracks the next busy state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         clr_ptr  <= '0;
         clr_busy <= 1'b0;
         wr_ready <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (clr_req) begin
                  state    <= CLEAR;
                  clr_ptr  <= '0;
                  clr_busy <= 1'b1;
                  wr_ready <= 1'b0;
               end else begin
                  clr_busy <= 1'b0;
                  wr_ready <= 1'b1;
               end
            end
            CLEAR: begin
               if (clr_ptr == ADDR_W'(WORDS - 1)) begin
                  state    <= IDLE;
                  clr_ptr  <= '0;
                  clr_busy <= 1'b0;
                  wr_ready <= 1'b1;
               end else begin
                  clr_ptr  <= clr_ptr + ADDR_W'(1);
               end
            end
            default: begin
               state    <= IDLE;
               clr_ptr  <= '0;
               clr_busy <= 1'b0;
               wr_ready <= 1'b0;
            end
         endcase
      end
   end

   // RAM write source: the clear sequencer owns the port while busy, else the host.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = lin_addr(wr_col, wr_row);
      ram_wdata = wr_data;
      if (state == CLEAR) begin
         ram_we    = 1'b1;
         ram_waddr = clr_ptr;
         ram_wdata = {CLEAR_COLOR, BLANK_CHAR};
      end else if (wr_valid && wr_ready && wr_in) begin
         ram_we    = 1'b1;
      end
   end

   // Simple dual-port RAM, read-first, contents not reset.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem[ram_waddr] <= ram_wdata;
      end
      ram_q <= mem[s1_addr];
   end

   // S1: address, range flag and cursor match.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_addr  <= '0;
         s1_oor   <= 1'b0;
         s1_cur   <= 1'b0;
      end else begin
         s1_valid <= rd_valid;
         s1_addr  <= rd_in ? lin_addr(rd_col, rd_row) : '0;
         s1_oor   <= ~rd_in;
         s1_cur   <= cur_hit;
      end
   end

   // S2: flags travel alongside the RAM read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_oor   <= 1'b0;
         s2_cur   <= 1'b0;
      end else begin
         s2_valid <= s1_valid;
         s2_oor   <= s1_oor;
         s2_cur   <= s1_cur;
      end
   end

   // S3: output register with blanking and cursor colour swap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         ascii      <= '0;
         text_color <= '0;
      end else begin
         out_valid <= s2_valid;
         if (s2_valid) begin
            if (s2_oor) begin
               ascii      <= BLANK_CHAR;
               text_color <= '0;
            end else begin
               ascii      <= q_char;
               text_color <= s2_cur ? {q_color[HALF-1:0], q_color[COLOR_W-1:HALF]} : q_color;
            end
         end
      end
   end

   // Frame counter driving the cursor blink phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (frame_start) begin
         if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt   <= blink_cnt + BLINK_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_text_char_fetch.sv
// Directed plus randomized checks of text_char_fetch against an array-based reference model.
module tb_text_char_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rd_valid;
   logic [6:0]  rd_col, rd_row;
   logic        out_valid;
   logic [7:0]  ascii, text_color;
   logic        wr_valid, wr_ready;
   logic [6:0]  wr_col, wr_row;
   logic [15:0] wr_data;
   logic        clr_req, clr_busy;
   logic        frame_start, cursor_en;
   logic [6:0]  cursor_col, cursor_row;

   int total = 0;
   int bad   = 0;

   logic [15:0] ref_mem [0:4799];
   int frames = 0;
   bit cur_en = 0;
   int cur_c = 0, cur_r = 0;

   text_char_fetch dut (
      .clk(clk), .rst_n(rst_n),
      .rd_valid(rd_valid), .rd_col(rd_col), .rd_row(rd_row),
      .out_valid(out_valid), .ascii(ascii), .text_color(text_color),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_col(wr_col), .wr_row(wr_row),
      .wr_data(wr_data), .clr_req(clr_req), .clr_busy(clr_busy),
      .frame_start(frame_start), .cursor_en(cursor_en),
      .cursor_col(cursor_col), .cursor_row(cursor_row)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected {colour, ascii} for a cell from the behavioural rules.
   function automatic logic [15:0] model(input int c, input int r);
      logic [15:0] d;
      if (c >= 80 || r >= 60) return 16'h0020;
      d = ref_mem[r * 80 + c];
      if (cur_en && ((frames / 30) % 2 == 1) && c == cur_c && r == cur_r)
         d = {d[11:8], d[15:12], d[7:0]};
      return d;
   endfunction

   task automatic wr(input int c, input int r, input logic [15:0] d);
      chk("wr_ready_before_write", wr_ready, 1);
      wr_valid = 1'b1; wr_col = 7'(c); wr_row = 7'(r); wr_data = d;
      step();
      wr_valid = 1'b0;
      if (c < 80 && r < 60) ref_mem[r * 80 + c] = d;
   endtask

   task automatic rd_chk(input int c, input int r, input string tag);
      logic [15:0] e;
      e = model(c, r);
      rd_valid = 1'b1; rd_col = 7'(c); rd_row = 7'(r);
      step();
      rd_valid = 1'b0;
      step();
      chk({tag, ".early"}, out_valid, 0);
      step();
      chk({tag, ".valid"}, out_valid, 1);
      chk({tag, ".ascii"}, ascii, e[7:0]);
      chk({tag, ".color"}, text_color, e[15:8]);
   endtask

   task automatic pulse_frames(input int n);
      for (int i = 0; i < n; i++) begin
         frame_start = 1'b1; step(); frame_start = 1'b0; step();
         frames++;
      end
   endtask

   initial begin
      int n, wr_hi;
      logic [15:0] exp_q [$];
      logic [15:0] e;

      rst_n = 1'b0; rd_valid = 0; rd_col = 0; rd_row = 0;
      wr_valid = 0; wr_col = 0; wr_row = 0; wr_data = 0;
      clr_req = 0; frame_start = 0; cursor_en = 0; cursor_col = 0; cursor_row = 0;
      #12;
      chk("rst.out_valid", out_valid, 0);
      chk("rst.ascii", ascii, 0);
      chk("rst.color", text_color, 0);
      chk("rst.clr_busy", clr_busy, 0);
      chk("rst.wr_ready", wr_ready, 0);
      step();
      rst_n = 1'b1;
      step();
      chk("post_rst.wr_ready", wr_ready, 1);

      // Basic write then read.
      wr(5, 2, 16'h1E41);
      step();
      rd_chk(5, 2, "wr_rd_5_2");
      chk("mem165", dut.mem[165], 16'h1E41);

      // Clear screen; a second request and a host write during clear are ignored.
      clr_req = 1'b1; step(); clr_req = 1'b0;
      n = 0; wr_hi = 0;
      while (clr_busy && n < 6000) begin
         n++;
         if (wr_ready) wr_hi++;
         clr_req  = (n == 100);
         wr_valid = (n < 10);
         wr_col = 7'd1; wr_row = 7'd1; wr_data = 16'hABCD;
         step();
      end
      clr_req = 0; wr_valid = 0;
      chk("clr.cycles", n, 4800);
      chk("clr.wr_ready_low", wr_hi, 0);
      chk("clr.done_wr_ready", wr_ready, 1);
      for (int i = 0; i < 4800; i++) ref_mem[i] = 16'h0F20;
      rd_chk(0, 0, "clr_0_0");
      rd_chk(79, 59, "clr_79_59");
      rd_chk(40, 30, "clr_40_30");
      rd_chk(1, 1, "clr_write_ignored");

      // Out-of-range reads and a discarded out-of-range write.
      rd_chk(80, 0, "oor_80_0");
      rd_chk(0, 60, "oor_0_60");
      wr(80, 0, 16'h5555);
      step();
      rd_chk(0, 1, "oor_wr_0_1_unchanged");

      // Random writes (some out of range) followed by random reads.
      for (int i = 0; i < 40; i++)
         wr($urandom_range(0, 85), $urandom_range(0, 63), 16'($urandom));
      for (int i = 0; i < 10; i++)
         wr($urandom_range(0, 79), 0, 16'($urandom));
      step();
      for (int i = 0; i < 30; i++)
         rd_chk($urandom_range(0, 85), $urandom_range(0, 63), "rand_rd");

      // Streamed row 0: 80 back-to-back requests, 80 consecutive results.
      for (int k = 0; k < 83; k++) begin
         if (k < 80) begin
            rd_valid = 1'b1; rd_col = 7'(k); rd_row = 7'd0;
            exp_q.push_back(model(k, 0));
         end else begin
            rd_valid = 1'b0;
         end
         step();
         if (k >= 2 && k < 82) begin
            e = exp_q.pop_front();
            chk("stream.valid", out_valid, 1);
            chk("stream.data", {text_color, ascii}, e);
         end else if (k == 82) begin
            chk("stream.end", out_valid, 0);
         end
      end

      // Cursor blink at (3,3).
      wr(3, 3, 16'h1E41);
      wr(4, 3, 16'h1E42);
      cursor_en = 1'b1; cursor_col = 7'd3; cursor_row = 7'd3;
      cur_en = 1; cur_c = 3; cur_r = 3;
      step();
      rd_chk(3, 3, "cur_0");
      chk("cur_0_exp", model(3, 3), 16'h1E41);
      pulse_frames(29);
      rd_chk(3, 3, "cur_29");
      pulse_frames(1);
      rd_chk(3, 3, "cur_30");
      chk("cur_30_exp", model(3, 3), 16'hE141);
      rd_chk(4, 3, "cur_neigh");
      pulse_frames(30);
      rd_chk(3, 3, "cur_60");
      cursor_en = 1'b0; cur_en = 0;

      // Reset in the middle of a clear with reads in flight.
      clr_req = 1'b1; step(); clr_req = 1'b0;
      for (int i = 0; i < 50; i++) begin
         rd_valid = 1'b1; rd_col = 7'd0; rd_row = 7'd0;
         step();
      end
      chk("mid.busy", clr_busy, 1);
      chk("mid.valid", out_valid, 1);
      chk("mid.data", {text_color, ascii}, 16'h0F20);
      rst_n = 1'b0;
      #1;
      chk("mid_rst.out_valid", out_valid, 0);
      chk("mid_rst.ascii", ascii, 0);
      chk("mid_rst.color", text_color, 0);
      chk("mid_rst.clr_busy", clr_busy, 0);
      chk("mid_rst.wr_ready", wr_ready, 0);
      rd_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rel.out_valid", out_valid, 0);
         chk("rel.clr_busy", clr_busy, 0);
         chk("rel.wr_ready", wr_ready, 1);
      end
      frames = 0;
      ref_mem[0] = 16'h0F20;
      rd_chk(0, 0, "rel_rd_0_0");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
